mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback selector for the 32-bit MIPS datapath. It captures results leaving the memory stage and selects the writeback value from ALU result, load data or link address. It drives the register file's `Rw`, `busW` and `RegWr` write port, exports the same write as a forwarding source, and counts retired instructions.

---
 rtl/mips_pkg.sv | 17 +
 rtl/load_extract.sv | 38 +++
 rtl/mem_wb_stage.sv | 155 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit MIPS datapath.
//   DATA_W               : datapath width (only 32 is supported)
//   WB_ALU/WB_MEM/WB_LINK: writeback source select encodings (3 aliases ALU)
//   LD_B/LD_H/LD_W       : load size encodings (3 aliases word)
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;

endpackage

// File: rtl/load_extract.sv
// Little-endian sub-word load extraction (purely combinational).
// Ports:
//   mem     in  32 : raw aligned memory word
//   ldsz    in  2  : load size (LD_B / LD_H / LD_W; 3 behaves as word)
//   ldsgn   in  1  : sign-extend byte/half results
//   addr_lo in  2  : byte address bits [1:0]
//   data    out 32 : extracted, extended load value
module load_extract
    import mips_pkg::*;
(
    input  logic [31:0] mem,
    input  logic [1:0]  ldsz,
    input  logic        ldsgn,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = mem[7:0];
            2'd1:    byte_v = mem[15:8];
            2'd2:    byte_v = mem[23:16];
            default: byte_v = mem[31:24];
        endcase
        // addr_lo[0] is ignored for halves; misalignment is trapped upstream.
        half_v = addr_lo[1] ? mem[31:16] : mem[15:0];

        case (ldsz)
            LD_B:    data = {{24{ldsgn & byte_v[7]}}, byte_v};
            LD_H:    data = {{16{ldsgn & half_v[15]}}, half_v};
            default: data = mem;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback selector.
// Captures memory-stage results, selects the writeback value (ALU, load
// data or link address), drives the register-file write port, mirrors it as
// a forwarding source and counts retired instructions.
// Optional feature macro: WB_SUBWORD_LOAD_EN
//   defined   : byte/half loads extracted and extended via load_extract
//   undefined : in_ldsz/in_ldsgn/in_addr_lo ignored, loads pass the raw word
// Ports:
//   clk, rst (async, active-high), stall, flush
//   in_valid, in_regwr, in_sel[1:0], in_rw[4:0], in_alu, in_mem, in_pc4,
//   in_ldsz[1:0], in_ldsgn, in_addr_lo[1:0]      : memory-stage results
//   Rw[4:0], busW, RegWr                         : register-file write port
//   fwd_en                                       : forwarding valid (= RegWr)
//   instret[31:0]                                : retired-instruction count
module mem_wb_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwr,
    input  logic [1:0]        in_sel,
    input  logic [4:0]        in_rw,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [1:0]        in_ldsz,
    input  logic              in_ldsgn,
    input  logic [1:0]        in_addr_lo,
    output logic [4:0]        Rw,
    output logic [DATA_W-1:0] busW,
    output logic              RegWr,
    output logic              fwd_en,
    output logic [31:0]       instret
);

    import mips_pkg::*;

    logic              valid_q, valid_d;
    logic              regwr_q, regwr_d;
    logic [1:0]        sel_q,   sel_d;
    logic [4:0]        rw_q,    rw_d;
    logic [DATA_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] mem_q,   mem_d;
    logic [DATA_W-1:0] pc4_q,   pc4_d;
    logic [31:0]       instret_q, instret_d;
    logic [DATA_W-1:0] load_data;

    // Flush only needs to kill valid/regwr; the payload simply holds.
    always_comb begin
        valid_d = valid_q;
        regwr_d = regwr_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            regwr_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            regwr_d = in_regwr;
            sel_d   = in_sel;
            rw_d    = in_rw;
            alu_d   = in_alu;
            mem_d   = in_mem;
            pc4_d   = in_pc4;
        end
    end

    // A slot retires when it leaves the stage, i.e. valid and not held.
    assign instret_d = instret_q + {31'd0, (valid_q & ~stall)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            sel_q     <= WB_ALU;
            rw_q      <= 5'd0;
            alu_q     <= '0;
            mem_q     <= '0;
            pc4_q     <= '0;
            instret_q <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            regwr_q   <= regwr_d;
            sel_q     <= sel_d;
            rw_q      <= rw_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            pc4_q     <= pc4_d;
            instret_q <= instret_d;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [1:0] ldsz_q,    ldsz_d;
    logic       ldsgn_q,   ldsgn_d;
    logic [1:0] addr_lo_q, addr_lo_d;

    always_comb begin
        ldsz_d    = ldsz_q;
        ldsgn_d   = ldsgn_q;
        addr_lo_d = addr_lo_q;
        if (!flush && !stall) begin
            ldsz_d    = in_ldsz;
            ldsgn_d   = in_ldsgn;
            addr_lo_d = in_addr_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldsz_q    <= LD_W;
            ldsgn_q   <= 1'b0;
            addr_lo_q <= 2'd0;
        end else begin
            ldsz_q    <= ldsz_d;
            ldsgn_q   <= ldsgn_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    load_extract u_load_extract (
        .mem     (mem_q),
        .ldsz    (ldsz_q),
        .ldsgn   (ldsgn_q),
        .addr_lo (addr_lo_q),
        .data    (load_data)
    );
`else
    // Sub-word controls are kept as ports but have no function here.
    logic unused_ld;
    assign unused_ld = ^{in_ldsz, in_ldsgn, in_addr_lo};
    assign load_data = mem_q;
`endif

    // r0 is hard-wired zero, so a write to it is never issued.
    assign RegWr   = valid_q & regwr_q & (rw_q != 5'd0);
    assign fwd_en  = RegWr;
    assign Rw      = RegWr ? rw_q : 5'd0;
    assign instret = instret_q;

    always_comb begin
        case (sel_q)
            WB_MEM:  busW = load_data;
            WB_LINK: busW = pc4_q;
            default: busW = alu_q;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

`ifdef WB_SUBWORD_LOAD_EN
    localparam bit SUBW = 1'b1;
`else
    localparam bit SUBW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_regwr, in_ldsgn;
    logic [1:0]  in_sel, in_ldsz, in_addr_lo;
    logic [4:0]  in_rw;
    logic [31:0] in_alu, in_mem, in_pc4;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        RegWr, fwd_en;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_regwr   (in_regwr),
        .in_sel     (in_sel),
        .in_rw      (in_rw),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_pc4     (in_pc4),
        .in_ldsz    (in_ldsz),
        .in_ldsgn   (in_ldsgn),
        .in_addr_lo (in_addr_lo),
        .Rw         (Rw),
        .busW       (busW),
        .RegWr      (RegWr),
        .fwd_en     (fwd_en),
        .instret    (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic wr, input logic [1:0] sel,
                          input logic [4:0] rw, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc4,
                          input logic [1:0] ldsz, input logic sgn,
                          input logic [1:0] alo);
        in_valid   = v;
        in_regwr   = wr;
        in_sel     = sel;
        in_rw      = rw;
        in_alu     = alu;
        in_mem     = mem;
        in_pc4     = pc4;
        in_ldsz    = ldsz;
        in_ldsgn   = sgn;
        in_addr_lo = alo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] rw,
                              input logic [31:0] bw, input logic we,
                              input logic [31:0] ir);
        chk({tag, ".Rw"},      {27'd0, Rw},     {27'd0, rw});
        chk({tag, ".busW"},    busW,            bw);
        chk({tag, ".RegWr"},   {31'd0, RegWr},  {31'd0, we});
        chk({tag, ".fwd_en"},  {31'd0, fwd_en}, {31'd0, we});
        chk({tag, ".instret"}, instret,         ir);
    endtask

    localparam logic [31:0] LW = 32'h80FF7F01;

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, 2'd0);

        // Asynchronous reset asserted between edges
        #2 rst = 1'b1;
        #1;
        expect_out("reset", 5'd0, 32'h0, 1'b0, 32'd0);
        step();
        rst = 1'b0;
        chk("reset.release.instret", instret, 32'd0);

        // ALU writeback, then load variants streamed back to back
        set_in(1, 1, 2'd0, 5'd8, 32'h12345678, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("alu", 5'd8, 32'h12345678, 1'b1, 32'd0);

        set_in(1, 1, 2'd1, 5'd9, 32'h11111111, LW, 32'h0, 2'd0, 1, 2'd3); step();
        expect_out("lb3s", 5'd9, SUBW ? 32'hFFFFFF80 : LW, 1'b1, 32'd1);

        set_in(1, 1, 2'd1, 5'd9, 32'h11111111, LW, 32'h0, 2'd0, 0, 2'd3); step();
        expect_out("lb3u", 5'd9, SUBW ? 32'h00000080 : LW, 1'b1, 32'd2);

        set_in(1, 1, 2'd1, 5'd10, 32'h0, LW, 32'h0, 2'd1, 1, 2'd2); step();
        expect_out("lh2s", 5'd10, SUBW ? 32'hFFFF80FF : LW, 1'b1, 32'd3);

        set_in(1, 1, 2'd1, 5'd10, 32'h0, LW, 32'h0, 2'd0, 1, 2'd2); step();
        expect_out("lb2s", 5'd10, SUBW ? 32'hFFFFFFFF : LW, 1'b1, 32'd4);

        set_in(1, 1, 2'd1, 5'd11, 32'h0, LW, 32'h0, 2'd1, 1, 2'd1); step();
        expect_out("lh1s", 5'd11, SUBW ? 32'h00007F01 : LW, 1'b1, 32'd5);

        set_in(1, 1, 2'd1, 5'd11, 32'h0, LW, 32'h0, 2'd3, 1, 2'd0); step();
        expect_out("lsz3", 5'd11, LW, 1'b1, 32'd6);

        set_in(1, 1, 2'd1, 5'd11, 32'h0, LW, 32'h0, 2'd0, 0, 2'd1); step();
        expect_out("lb1u", 5'd11, SUBW ? 32'h0000007F : LW, 1'b1, 32'd7);

        // Link and reserved select
        set_in(1, 1, 2'd2, 5'd31, 32'hBAD0BAD0, LW, 32'h00400008, 2'd2, 0, 2'd0); step();
        expect_out("link", 5'd31, 32'h00400008, 1'b1, 32'd8);

        set_in(1, 1, 2'd3, 5'd4, 32'hCAFEF00D, 32'h2, 32'h1, 2'd2, 0, 2'd0); step();
        expect_out("sel3", 5'd4, 32'hCAFEF00D, 1'b1, 32'd9);

        // Suppressed writes still retire; bubbles do not
        set_in(1, 1, 2'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("r0", 5'd0, 32'hDEADBEEF, 1'b0, 32'd10);

        set_in(1, 0, 2'd0, 5'd5, 32'h5, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("nowr", 5'd0, 32'h5, 1'b0, 32'd11);

        set_in(0, 1, 2'd0, 5'd6, 32'h6, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("bubble", 5'd0, 32'h6, 1'b0, 32'd12);

        // Stall holds everything
        set_in(1, 1, 2'd0, 5'd12, 32'hA5A5A5A5, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("pre_stall", 5'd12, 32'hA5A5A5A5, 1'b1, 32'd12);

        stall = 1'b1;
        set_in(1, 1, 2'd0, 5'd3, 32'h0, 32'h0, 32'h0, 2'd2, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall", 5'd12, 32'hA5A5A5A5, 1'b1, 32'd12);
        end

        // Flush wins over stall and the held slot is not counted
        flush = 1'b1; step();
        chk("stflush.RegWr",   {31'd0, RegWr}, 32'd0);
        chk("stflush.Rw",      {27'd0, Rw},    32'd0);
        chk("stflush.instret", instret,        32'd12);

        stall = 1'b0; flush = 1'b0;
        set_in(1, 1, 2'd0, 5'd13, 32'h13, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("post_flush", 5'd13, 32'h13, 1'b1, 32'd12);

        // Flush alone: outgoing slot retires, incoming one is killed
        flush = 1'b1;
        set_in(1, 1, 2'd0, 5'd14, 32'h14, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        chk("flush.RegWr",   {31'd0, RegWr}, 32'd0);
        chk("flush.instret", instret,        32'd13);
        flush = 1'b0;

        set_in(1, 1, 2'd0, 5'd15, 32'h15, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("refill", 5'd15, 32'h15, 1'b1, 32'd13);

        // Counter wrap, starting from a preset value
        force dut.instret_q = 32'hFFFFFFFF;
        #1 release dut.instret_q;
        chk("wrap.preset", instret, 32'hFFFFFFFF);
        set_in(1, 1, 2'd0, 5'd16, 32'h16, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("wrap", 5'd16, 32'h16, 1'b1, 32'd0);

        set_in(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        chk("wrap.next", instret, 32'd1);

        // Reset mid-stream drops the captured instruction
        set_in(1, 1, 2'd0, 5'd17, 32'h17, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("pre_rst", 5'd17, 32'h17, 1'b1, 32'd1);
        #2 rst = 1'b1;
        #1;
        expect_out("midrst", 5'd0, 32'h0, 1'b0, 32'd0);
        step();
        rst = 1'b0;
        set_in(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, 2'd0); step();
        expect_out("after_rst", 5'd0, 32'h0, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
